fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares the write side of the single-clock 64-entry FIFO (`fifo_single_clk`) among four requesters. Each requester offers 8-bit beats with a req/ack handshake. The arbiter grants one requester at a time and registers the winning beat onto the FIFO `wr_en`/`buf_in` pins. It uses the FIFO's `fifo_counter` to guarantee that no write is ever issued into a full FIFO, including writes still in flight.

---
 rtl/fifo_wr_arbiter_if.sv | 25 ++
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle shared by the four requesters, the arbiter and the FIFO write pins.
// Handshake: a beat moves at a rising edge where req[i] && ack[i]; ack never looks at req.
interface fifo_wr_arbiter_if #(
    parameter int DW = 8,
    parameter int CW = 8
);
    logic [3:0]      req;
    logic [4*DW-1:0] din;
    logic [3:0]      ack;
    logic [1:0]      gnt_id;
    logic            busy;
    logic [CW-1:0]   fifo_counter;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_din;

    modport master (
        output req, din, fifo_counter,
        input  ack, gnt_id, busy, fifo_wr_en, fifo_din
    );

    modport slave (
        input  req, din, fifo_counter,
        output ack, gnt_id, busy, fifo_wr_en, fifo_din
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the write port of a 64-entry FIFO among four requesters.
// Define FIFO_ARB_BURST_EN to let a winner keep the port for up to BURST_LEN beats.
module fifo_wr_arbiter #(
    parameter int DW        = 8,
    parameter int DEPTH     = 64,
    parameter int CW        = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    fifo_wr_arbiter_if.slave bus,
    output logic             dbg_state_o,
    output logic [1:0]       dbg_rr_ptr_o,
    output logic [3:0]       dbg_beat_cnt_o
);
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif
    localparam logic [3:0] LIMIT   = BURST_ON ? 4'(BURST_LEN) : 4'd1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    state_t        state_q;
    logic [1:0]    rr_ptr_q;
    logic [1:0]    gnt_q;
    logic [3:0]    beat_cnt_q;
    logic          wr_en_q;
    logic [DW-1:0] din_q;

    logic [CW:0]   occ;
    logic          space;
    logic          accept;
    logic          grant_end;
    logic [3:0]    beat_cnt_d;
    logic [DW-1:0] beat;
    logic [2:0]    pick_idle;
    logic [2:0]    pick_next;
    logic [3:0]    ack;

    // Returns {found, index}; scanning downward leaves the lowest offset from start as winner.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // The registered strobe is a write the FIFO counter has not seen yet.
    assign occ   = {1'b0, bus.fifo_counter} + {{CW{1'b0}}, wr_en_q};
    assign space = occ < DEPTH_W;

    always_comb begin
        beat       = bus.din[gnt_q*DW +: DW];
        accept     = (state_q == GRANT) && bus.req[gnt_q] && space;
        beat_cnt_d = beat_cnt_q + 4'd1;
        grant_end  = (state_q == GRANT) &&
                     (!bus.req[gnt_q] || (accept && (beat_cnt_d == LIMIT)));
        pick_idle  = rr_pick(bus.req, rr_ptr_q);
        pick_next  = rr_pick(bus.req, gnt_q + 2'd1);
        ack        = 4'b0000;
        if ((state_q == GRANT) && space) ack[gnt_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 2'd0;
            gnt_q      <= 2'd0;
            beat_cnt_q <= 4'd0;
            wr_en_q    <= 1'b0;
            din_q      <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_idle[2]) begin
                        state_q    <= GRANT;
                        gnt_q      <= pick_idle[1:0];
                        beat_cnt_q <= 4'd0;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        wr_en_q    <= 1'b1;
                        din_q      <= beat;
                        beat_cnt_q <= beat_cnt_d;
                    end
                    // Handover re-arbitrates in the same edge so the port never idles.
                    if (grant_end) begin
                        rr_ptr_q   <= gnt_q + 2'd1;
                        beat_cnt_q <= 4'd0;
                        if (pick_next[2]) gnt_q   <= pick_next[1:0];
                        else              state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack        = ack;
    assign bus.gnt_id     = gnt_q;
    assign bus.busy       = (state_q == GRANT);
    assign bus.fifo_wr_en = wr_en_q;
    assign bus.fifo_din   = din_q;

    assign dbg_state_o    = (state_q == GRANT);
    assign dbg_rr_ptr_o   = rr_ptr_q;
    assign dbg_beat_cnt_o = beat_cnt_q;
endmodule
